imem_loader: RTL and testbench

- Boot-time program loader upstream of the single-cycle core.
- Receives a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes each word into instruction memory at word addresses 0, 1, 2, …
- Holds the core (PC register reset) in reset until the image is loaded and its checksum verifies.

---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/word_assembler.sv | 45 ++++
 rtl/imem_loader.sv | 168 ++++++++++++++++
 tb/tb_imem_loader.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

    // Stream framing
    localparam int unsigned HDR_W          = 16;
    localparam int unsigned BYTES_PER_WORD = 4;

    // Loader FSM state encoding
    localparam logic [2:0] HDR_HI  = 3'd0;
    localparam logic [2:0] HDR_LO  = 3'd1;
    localparam logic [2:0] PAYLOAD = 3'd2;
    localparam logic [2:0] CHECK   = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;
    localparam logic [2:0] ERROR   = 3'd5;

endpackage

// File: rtl/word_assembler.sv
// Shifts stream bytes MSB-first into a 32-bit word; pulses word_valid
// combinationally on the transfer that delivers the last byte of a word.
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clock,
    input  logic        rst,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
);

    // Only the first three bytes need storing; the fourth arrives with word_valid.
    logic [23:0] shift_q, shift_d;
    logic [1:0]  idx_q, idx_d;

    // Next-state: shift in a byte and advance the byte index on each accepted byte
    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        if (shift_en) begin
            shift_d = {shift_q[15:0], byte_in};
            idx_d   = idx_q + 2'd1;
        end
    end

    // Assembled word and completion pulse
    always_comb begin
        word       = {shift_q, byte_in};
        word_valid = shift_en && (idx_q == 2'(BYTES_PER_WORD - 1));
    end

    // State registers
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a header/payload/checksum byte stream, writes big-endian
// words to instruction memory and releases the core reset once verified.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              load_done,
    output logic              load_err
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [2:0]        state_q, state_d;
    logic [7:0]        n_hi_q, n_hi_d;
    logic [HDR_W-1:0]  n_q, n_d;
    // One extra bit so a full DEPTH-word image never wraps the count.
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [7:0]        chk_q, chk_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic              core_rst_q, core_rst_d;
    logic              load_done_q, load_done_d;
    logic              load_err_q, load_err_d;

    logic              xfer;
    logic [HDR_W-1:0]  n_full;
    logic              last_word;
    logic [31:0]       word;
    logic              word_valid;

    // Ready is a pure function of state so the source can rely on it a cycle ahead
    always_comb begin
        in_ready = (state_q == HDR_HI) || (state_q == HDR_LO) ||
                   (state_q == PAYLOAD) || (state_q == CHECK);
        xfer      = in_valid && in_ready;
        n_full    = {n_hi_q, in_data};
        last_word = (32'(cnt_q) + 32'd1) == 32'(n_q);
    end

    word_assembler u_word_assembler (
        .clock      (clock),
        .rst        (rst),
        .shift_en   (xfer && (state_q == PAYLOAD)),
        .byte_in    (in_data),
        .word       (word),
        .word_valid (word_valid)
    );

    // Loader FSM, checksum, address counter and registered outputs
    always_comb begin
        state_d      = state_q;
        n_hi_d       = n_hi_q;
        n_d          = n_q;
        cnt_d        = cnt_q;
        chk_d        = chk_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        core_rst_d   = core_rst_q;
        load_done_d  = load_done_q;
        load_err_d   = load_err_q;

        // Every byte ahead of the check byte folds into the running XOR.
        if (xfer && (state_q != CHECK)) begin
            chk_d = chk_q ^ in_data;
        end

        case (state_q)
            HDR_HI: begin
                if (xfer) begin
                    n_hi_d  = in_data;
                    state_d = HDR_LO;
                end
            end
            HDR_LO: begin
                if (xfer) begin
                    n_d = n_full;
                    if (32'(n_full) > DEPTH) begin
                        state_d    = ERROR;
                        load_err_d = 1'b1;
                    end else if (n_full == '0) begin
                        state_d = CHECK;
                    end else begin
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (word_valid) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = cnt_q[ADDR_W-1:0];
                    imem_wdata_d = word;
                    cnt_d        = cnt_q + 1'b1;
                    if (last_word) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                if (xfer) begin
                    if (in_data == chk_q) begin
                        state_d     = DONE;
                        load_done_d = 1'b1;
                        core_rst_d  = 1'b0;
                    end else begin
                        state_d    = ERROR;
                        load_err_d = 1'b1;
                    end
                end
            end
            // DONE and ERROR are terminal until reset.
            default: begin
                state_d = state_q;
            end
        endcase
    end

    // Output assignments
    always_comb begin
        imem_we    = imem_we_q;
        imem_addr  = imem_addr_q;
        imem_wdata = imem_wdata_q;
        core_rst   = core_rst_q;
        load_done  = load_done_q;
        load_err   = load_err_q;
    end

    // State registers
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q      <= HDR_HI;
            n_hi_q       <= '0;
            n_q          <= '0;
            cnt_q        <= '0;
            chk_q        <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            core_rst_q   <= 1'b1;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_hi_q       <= n_hi_d;
            n_q          <= n_d;
            cnt_q        <= cnt_d;
            chk_q        <= chk_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            core_rst_q   <= core_rst_d;
            load_done_q  <= load_done_d;
            load_err_q   <= load_err_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected writes, a monitor
// pops and compares them on every write strobe.
module tb_imem_loader;

    logic        clock = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        imem_we;
    logic [11:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        load_done;
    logic        load_err;

    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  strobes = 0;

    imem_loader #(.ADDR_W(12)) dut (
        .clock      (clock),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expected write
    always @(negedge clock) begin
        wr_t e;
        if (imem_we === 1'b1) begin
            strobes++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: addr %h data %h with no write expected",
                         imem_addr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(imem_addr), 32'(e.addr));
                chk("wr_data", imem_wdata, e.data);
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_we"}, 32'(imem_we), 32'd0);
        chk({tag, "_addr"}, 32'(imem_addr), 32'd0);
        chk({tag, "_wdata"}, imem_wdata, 32'd0);
        chk({tag, "_core_rst"}, 32'(core_rst), 32'd1);
        chk({tag, "_done"}, 32'(load_done), 32'd0);
        chk({tag, "_err"}, 32'(load_err), 32'd0);
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clock);
        check_reset_vals("rst");
        rst = 1'b1;
        @(negedge clock);
        exp_q.delete();
        strobes = 0;
    endtask

    // Offer one byte until it is accepted, bounded by a cycle budget
    task automatic xfer(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data = b;
        while (!in_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL xfer_timeout: byte %h not accepted, in_ready %b", b, in_ready);
        end else begin
            @(negedge clock);
        end
    endtask

    task automatic send(input logic [7:0] s[$], input int idle_pct);
        foreach (s[i]) begin
            if (idle_pct > 0 && $urandom_range(0, 99) < idle_pct) begin
                in_valid = 1'b0;
                in_data = 8'hxx;
                repeat ($urandom_range(1, 2)) @(negedge clock);
            end
            xfer(s[i]);
        end
        in_valid = 1'b0;
    endtask

    task automatic push_normal();
        exp_q.push_back({12'd0, 32'h2001_0005});
        exp_q.push_back({12'd1, 32'h8C22_0004});
    endtask

    task automatic check_final(input string tag, input logic done, input logic err,
                               input int nstrobes);
        repeat (3) @(negedge clock);
        chk({tag, "_done"}, 32'(load_done), 32'(done));
        chk({tag, "_err"}, 32'(load_err), 32'(err));
        chk({tag, "_core_rst"}, 32'(core_rst), 32'(!done));
        chk({tag, "_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_strobes"}, 32'(strobes), 32'(nstrobes));
        chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] normal[$];
        logic [7:0] bad[$];
        logic [7:0] s[$];

        normal = '{8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h8C, 8'h22, 8'h00, 8'h04,
                   8'h8C};
        bad = normal;
        bad[10] = 8'h8D;

        // Normal load, back-to-back bytes
        do_reset();
        push_normal();
        send(normal, 0);
        chk("normal_done_next_cycle", 32'(load_done), 32'd1);
        chk("normal_core_rst_next_cycle", 32'(core_rst), 32'd0);
        check_final("normal", 1'b1, 1'b0, 2);
        chk("normal_last_addr_held", 32'(imem_addr), 32'd1);
        chk("normal_last_data_held", imem_wdata, 32'h8C22_0004);

        // Bad checksum
        do_reset();
        push_normal();
        send(bad, 0);
        chk("badchk_err_next_cycle", 32'(load_err), 32'd1);
        check_final("badchk", 1'b0, 1'b1, 2);

        // Oversize header: N = 4097
        do_reset();
        s = '{8'h10, 8'h01};
        send(s, 0);
        chk("oversize_err_next_cycle", 32'(load_err), 32'd1);
        chk("oversize_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_data = 8'h00;
        repeat (3) begin
            @(negedge clock);
            chk("oversize_still_not_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        check_final("oversize", 1'b0, 1'b1, 0);

        // Empty image
        do_reset();
        s = '{8'h00, 8'h00, 8'h00};
        send(s, 0);
        check_final("empty", 1'b1, 1'b0, 0);

        // Backpressure: random idle cycles between bytes
        do_reset();
        push_normal();
        send(normal, 60);
        check_final("bp", 1'b1, 1'b0, 2);

        // Reset after six bytes, then a full reload
        do_reset();
        exp_q.push_back({12'd0, 32'h2001_0005});
        s = normal[0:5];
        send(s, 0);
        #2;
        rst = 1'b0;
        #1;
        check_reset_vals("midrst");
        chk("midrst_word0_seen", 32'(exp_q.size()), 32'd0);
        @(negedge clock);
        check_reset_vals("midrst_hold");
        rst = 1'b1;
        @(negedge clock);
        strobes = 0;
        push_normal();
        send(normal, 0);
        check_final("reload", 1'b1, 1'b0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
